// File: rtl/seq_signed_mult_if.sv
// Start/done handshake and result bus for seq_signed_mult.
//   master : drives start, a, b; observes busy, done, full_product, result, overflow
//   slave  : the multiplier side
interface seq_signed_mult_if #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 16
);
  logic                         start;
  logic [A_WIDTH-1:0]           a;
  logic [B_WIDTH-1:0]           b;
  logic                         busy;
  logic                         done;
  logic [A_WIDTH+B_WIDTH-1:0]   full_product;
  logic [OUT_WIDTH-1:0]         result;
  logic                         overflow;

  modport master (
    output start, a, b,
    input  busy, done, full_product, result, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, full_product, result, overflow
  );
endinterface

// File: rtl/seq_signed_mult.sv
// Multi-cycle signed multiplier: sign-magnitude shift-add, one multiplier bit
// per clock. Produces the exact product plus a rounded (half toward +inf),
// right-shifted by FRAC_BITS, saturated OUT_WIDTH result.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any operation in flight)
//   bus  : slave side of seq_signed_mult_if (start/a/b in; busy/done/
//          full_product/result/overflow out, all registered)
// Latency: start accepted at edge k -> done visible after edge k+B_WIDTH+1.
module seq_signed_mult #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic              clk,
  input  logic              rst,
  seq_signed_mult_if.slave  bus
);
  localparam int P  = A_WIDTH + B_WIDTH;
  localparam int CW = $clog2(B_WIDTH + 1);

  // Scaling constants, all at P+1 bits so the rounding add cannot wrap.
  localparam logic signed [P:0] ONE   = (P+1)'(1);
  localparam logic signed [P:0] RND   = (ONE <<< FRAC_BITS) >>> 1; // 0 when FRAC_BITS==0
  localparam logic signed [P:0] MAX_V = (ONE <<< (OUT_WIDTH-1)) - ONE;
  localparam logic signed [P:0] MIN_V = -(ONE <<< (OUT_WIDTH-1));

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state;
  logic [P-1:0]       acc;
  logic [P-1:0]       mcand;   // |a| pre-shifted to the current bit position
  logic [B_WIDTH-1:0] mplier;  // |b|, consumed LSB first
  logic [CW-1:0]      cnt;
  logic               sign;

  // Magnitudes: the most-negative value negates to itself, which read as
  // unsigned is exactly 2^(W-1).
  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;
  assign a_mag = bus.a[A_WIDTH-1] ? (~bus.a + A_WIDTH'(1)) : bus.a;
  assign b_mag = bus.b[B_WIDTH-1] ? (~bus.b + B_WIDTH'(1)) : bus.b;

  // Final signed product and scaling. acc never exceeds 2^(P-2), so the
  // negation fits; a zero accumulator negates to zero (no -0).
  logic signed [P-1:0] prod;
  logic signed [P:0]   rnd_sum;
  logic signed [P:0]   scaled;
  assign prod    = $signed(sign ? (~acc + P'(1)) : acc);
  assign rnd_sum = {prod[P-1], prod} + RND;
  assign scaled  = rnd_sum >>> FRAC_BITS;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      acc              <= '0;
      mcand            <= '0;
      mplier           <= '0;
      cnt              <= '0;
      sign             <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.full_product <= '0;
      bus.result       <= '0;
      bus.overflow     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand    <= {{B_WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            sign     <= bus.a[A_WIDTH-1] ^ bus.b[B_WIDTH-1];
            acc      <= '0;
            cnt      <= CW'(B_WIDTH);
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FINISH;
        end
        FINISH: begin
          bus.full_product <= prod;
          if (scaled > MAX_V) begin
            bus.result   <= MAX_V[OUT_WIDTH-1:0];
            bus.overflow <= 1'b1;
          end else if (scaled < MIN_V) begin
            bus.result   <= MIN_V[OUT_WIDTH-1:0];
            bus.overflow <= 1'b1;
          end else begin
            bus.result   <= scaled[OUT_WIDTH-1:0];
            bus.overflow <= 1'b0;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_signed_mult.md
Name: seq_signed_mult

Overview:
Parametrised, multi-cycle signed multiplier for the audio datapath, used for gain, mixing and filter-coefficient products. It takes a start/done handshake and forms the product by sign-magnitude shift-add, one multiplier bit per clock. It delivers the full-width two's-complement product plus a rounded, saturated fixed-point result (default Q1.15 x Q1.15 -> Q1.15). It replaces wide combinational multipliers where timing or area is tight.

Parameters:
A_WIDTH, 16, width of signed operand a.
B_WIDTH, 16, width of signed operand b; iteration count of the multiplier.
OUT_WIDTH, 16, width of the scaled signed result; must be <= A_WIDTH+B_WIDTH.
FRAC_BITS, 15, right-shift applied to the full product before saturation; must be < A_WIDTH+B_WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  request; sampled only in IDLE.
a  in  A_WIDTH  signed multiplicand; captured when start is accepted.
b  in  B_WIDTH  signed multiplier; captured when start is accepted.
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse when the outputs update.
full_product  out  A_WIDTH+B_WIDTH  exact signed product.
result  out  OUT_WIDTH  rounded, shifted, saturated signed product.
overflow  out  1  set when result saturated; valid with done and held until next done.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset: FSM -> IDLE. busy=0, done=0, full_product=0, result=0, overflow=0. Reset mid-operation aborts the operation; no done is produced for it.
- FSM states are IDLE, RUN and FINISH.
- IDLE, start=1 at edge k:
  - Latch the magnitudes |a| (A_WIDTH unsigned) and |b| (B_WIDTH unsigned). Magnitude = two's-complement negate when MSB=1.
  - Most-negative inputs are exact: |-2^(A_WIDTH-1)| = 2^(A_WIDTH-1) fits unsigned.
  - Latch sign = a[MSB] XOR b[MSB].
  - Clear the accumulator, load the bit counter = B_WIDTH, set busy=1, go to RUN.
- RUN, one bit per edge:
  - If the current LSB of |b| is 1, add |a| shifted to that bit position into the unsigned A_WIDTH+B_WIDTH accumulator.
  - Shift |b| right and decrement the counter.
  - After B_WIDTH iterations go to FINISH.
- FINISH, one edge:
  - full_product = sign ? -acc : acc. A zero product is always +0, whatever the sign.
  - Scaled value: if FRAC_BITS>0, add 2^(FRAC_BITS-1), then arithmetic-shift right by FRAC_BITS (round half toward +inf). If FRAC_BITS=0, no rounding.
  - Perform the rounding add at A_WIDTH+B_WIDTH+1 bits so it cannot wrap.
  - If the scaled value > 2^(OUT_WIDTH-1)-1: result = max positive, overflow=1.
  - If the scaled value < -2^(OUT_WIDTH-1): result = min negative, overflow=1.
  - Otherwise result = scaled value, overflow=0.
  - Set done=1, busy=0, go to IDLE.
- Latency:
  - start sampled at edge k; done high in the cycle after edge k+B_WIDTH+1.
  - Throughput is one product per B_WIDTH+2 cycles.
- done is a single-cycle pulse and is cleared at the next edge.
- full_product, result and overflow hold their values until the next done.
- start while busy=1 is ignored; no queueing.
- start in the same cycle that done=1 is accepted (FSM is in IDLE); back-to-back operation is legal.
- a and b may change freely after acceptance; only the latched copies are used.

Test Plan:
- Reset, then a=16384, b=16384, start -> done after 18 cycles; full_product=0x10000000, result=8192, overflow=0; busy high for exactly 17 cycles.
- a=-32768, b=-32768 -> full_product=0x40000000, result=32767 (0x7FFF), overflow=1.
- a=-32768, b=1 -> full_product=-32768 (0xFFFF8000), result=-1, overflow=0. a=0, b=-5 -> full_product=0, result=0.
- a=12345, b=-3: full_product=-37035; with FRAC_BITS=0 and OUT_WIDTH=32 (second instance) -> result=-37035, overflow=0.
- Pulse start again at cycles 3 and 10 of a running operation -> both ignored, single done. Then start in the done cycle -> second operation completes 18 cycles later with correct result.
- Assert rst at RUN cycle 8 -> next cycle busy=0, done=0, all outputs 0, and no done appears afterwards. A new start then completes normally.
- Randomised a/b over 10k operations, with A_WIDTH=12, B_WIDTH=20 (second instance) -> full_product matches the signed reference model exactly.
